// File: rtl/memory_bus_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the DRAM port.
// master: the arbiter's view. slave: the requesters plus DRAM, i.e. the environment.
interface memory_bus_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 21,
  parameter int unsigned DATA_WIDTH = 64
);
  // Requester side: packed per-requester fields, requester i at [i*W +: W]
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;

  // DRAM side
  logic                          mem_req_valid;
  logic                          mem_req_write;
  logic [ADDR_WIDTH-1:0]         mem_req_addr;
  logic [DATA_WIDTH-1:0]         mem_req_wdata;
  logic                          mem_req_ready;
  logic                          mem_rsp_valid;
  logic [DATA_WIDTH-1:0]         mem_rsp_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Round-robin arbiter sharing the single DRAM bus between fetch, load and store.
// One transaction in flight at a time; a watchdog completes hung transactions
// with zero data and raises a sticky timeout_err.
module memory_bus_arbiter #(
  parameter int unsigned NUM_REQ        = 3,
  parameter int unsigned ADDR_WIDTH     = 21,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  memory_bus_arbiter_if.master bus,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned OW = $clog2(NUM_REQ);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [OW-1:0]         owner_q, owner_d;
  logic [OW-1:0]         last_grant_q, last_grant_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  timeout_d;

  logic                  grant_found;
  logic [OW-1:0]         grant_idx;
  logic [OW-1:0]         cand;
  logic                  timer_expired;

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign timer_expired = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  assign bus.req_ready     = req_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.mem_req_valid = mem_valid_q;
  assign bus.mem_req_write = mem_write_q;
  assign bus.mem_req_addr  = mem_addr_q;
  assign bus.mem_req_wdata = mem_wdata_q;

  // Round-robin pick: first requesting index after last_grant, wrapping
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = OW'((32'(last_grant_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Next-state, watchdog and registered-output values
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    timer_d      = timer_q;
    mem_valid_d  = mem_valid_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    timeout_d    = timeout_err;

    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d                = grant_idx;
          last_grant_d           = grant_idx;
          mem_valid_d            = 1'b1;
          mem_write_d            = bus.req_write[grant_idx];
          mem_addr_d             = addr_arr[grant_idx];
          mem_wdata_d            = wdata_arr[grant_idx];
          req_ready_d[grant_idx] = 1'b1;
          timer_d                = '0;
          state_d                = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = timer_q + 1'b1;
        if (bus.mem_req_ready) begin
          mem_valid_d = 1'b0;
          state_d     = WAIT_RSP;
        end else if (timer_expired) begin
          mem_valid_d          = 1'b0;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          timeout_d            = 1'b1;
          state_d              = IDLE;
        end
      end
      WAIT_RSP: begin
        timer_d = timer_q + 1'b1;
        if (bus.mem_rsp_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = bus.mem_rsp_rdata;
          state_d              = IDLE;
        end else if (timer_expired) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_rdata_d          = '0;
          timeout_d            = 1'b1;
          state_d              = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q      <= '0;
      last_grant_q <= OW'(NUM_REQ - 1);
      timer_q      <= '0;
      mem_valid_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      timer_q      <= timer_d;
      mem_valid_q  <= mem_valid_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      busy         <= (state_d != IDLE);
      timeout_err  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: single read, round-robin rotation,
// stalled write, watchdog expiry, last-cycle response, reset mid-transaction.
module tb_memory_bus_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned AW      = 21;
  localparam int unsigned DW      = 64;
  localparam int unsigned TO      = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  logic timeout_err;
  int   checks = 0;
  int   errors = 0;

  memory_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  memory_bus_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [2:0] oh;
    int unsigned e;

    reset             = 1'b1;
    bus.req_valid     = '0;
    bus.req_write     = '0;
    bus.req_addr      = '0;
    bus.req_wdata     = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    tick;
    tick;

    // Reset state
    chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'h0);
    chk("rst_mem_valid", 64'(bus.mem_req_valid), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_timeout", 64'(timeout_err), 64'h0);

    // Single read from fetch
    reset                    = 1'b0;
    bus.req_valid            = 3'b001;
    bus.req_write            = 3'b000;
    bus.req_addr[0*AW +: AW] = 21'h00100;
    bus.mem_req_ready        = 1'b1;
    tick;
    chk("rd_req_ready", 64'(bus.req_ready), 64'h1);
    chk("rd_mem_valid", 64'(bus.mem_req_valid), 64'h1);
    chk("rd_mem_addr", 64'(bus.mem_req_addr), 64'h00100);
    chk("rd_mem_write", 64'(bus.mem_req_write), 64'h0);
    chk("rd_busy", 64'(busy), 64'h1);
    bus.req_valid = 3'b000;
    tick;
    chk("rd_ready_pulse", 64'(bus.req_ready), 64'h0);
    chk("rd_mem_valid_drop", 64'(bus.mem_req_valid), 64'h0);
    chk("rd_no_early_rsp", 64'(bus.rsp_valid), 64'h0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hDEADBEEF;
    tick;
    chk("rd_rsp_valid", 64'(bus.rsp_valid), 64'h1);
    chk("rd_rsp_rdata", bus.rsp_rdata, 64'hDEADBEEF);
    chk("rd_busy_done", 64'(busy), 64'h0);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    tick;
    chk("rd_rsp_pulse", 64'(bus.rsp_valid), 64'h0);

    // All requesters continuously from reset: grants 0,1,2,0,1,2
    reset = 1'b1;
    tick;
    reset             = 1'b0;
    bus.req_valid     = 3'b111;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e  = k % 3;
      oh = 3'b001 << e;
      bus.mem_rsp_rdata = 64'h1000 + 64'(k);
      tick;
      chk("rr_req_ready", 64'(bus.req_ready), 64'(oh));
      bus.req_valid = bus.req_valid & ~oh;
      tick;
      tick;
      chk("rr_rsp_owner", 64'(bus.rsp_valid), 64'(oh));
      chk("rr_rsp_rdata", bus.rsp_rdata, 64'h1000 + 64'(k));
      bus.req_valid = bus.req_valid | oh;
    end
    bus.req_valid     = 3'b000;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;

    // Stalled write from load port: DRAM not ready for 5 cycles
    bus.req_valid              = 3'b010;
    bus.req_write              = 3'b010;
    bus.req_addr[1*AW +: AW]   = 21'h1ABCD;
    bus.req_wdata[1*DW +: DW]  = 64'h0123456789ABCDEF;
    tick;
    chk("wr_req_ready", 64'(bus.req_ready), 64'h2);
    chk("wr_mem_write", 64'(bus.mem_req_write), 64'h1);
    bus.req_valid = 3'b000;
    bus.req_write = 3'b000;
    for (int j = 0; j < 6; j++) begin
      chk("wr_hold_valid", 64'(bus.mem_req_valid), 64'h1);
      chk("wr_hold_addr", 64'(bus.mem_req_addr), 64'h1ABCD);
      chk("wr_hold_wdata", bus.mem_req_wdata, 64'h0123456789ABCDEF);
      chk("wr_hold_busy", 64'(busy), 64'h1);
      if (j == 5) bus.mem_req_ready = 1'b1;
      tick;
    end
    bus.mem_req_ready = 1'b0;
    chk("wr_wait_valid", 64'(bus.mem_req_valid), 64'h0);
    chk("wr_wait_busy", 64'(busy), 64'h1);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'h55;
    tick;
    chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    chk("wr_rsp_rdata", bus.rsp_rdata, 64'h55);
    chk("wr_timeout", 64'(timeout_err), 64'h0);
    bus.mem_rsp_valid = 1'b0;

    // Watchdog: store port, DRAM never accepts
    bus.req_valid            = 3'b100;
    bus.req_addr[2*AW +: AW] = 21'h00042;
    tick;
    chk("to_req_ready", 64'(bus.req_ready), 64'h4);
    chk("to_mem_addr", 64'(bus.mem_req_addr), 64'h00042);
    bus.req_valid = 3'b000;
    repeat (7) tick;
    chk("to_last_cycle_valid", 64'(bus.mem_req_valid), 64'h1);
    chk("to_last_cycle_rsp", 64'(bus.rsp_valid), 64'h0);
    chk("to_last_cycle_err", 64'(timeout_err), 64'h0);
    tick;
    chk("to_rsp_valid", 64'(bus.rsp_valid), 64'h4);
    chk("to_rsp_rdata", bus.rsp_rdata, 64'h0);
    chk("to_err_set", 64'(timeout_err), 64'h1);
    chk("to_mem_valid", 64'(bus.mem_req_valid), 64'h0);
    chk("to_busy", 64'(busy), 64'h0);

    // Next request after a timeout completes normally; error stays sticky
    bus.req_valid            = 3'b001;
    bus.req_addr[0*AW +: AW] = 21'h00200;
    bus.mem_req_ready        = 1'b1;
    tick;
    chk("post_to_ready", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 3'b000;
    tick;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hCAFE;
    tick;
    chk("post_to_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("post_to_rdata", bus.rsp_rdata, 64'hCAFE);
    chk("post_to_sticky", 64'(timeout_err), 64'h1);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;

    // Response arriving exactly at timer = TIMEOUT_CYCLES-1
    reset = 1'b1;
    tick;
    chk("rst_clears_err", 64'(timeout_err), 64'h0);
    reset                    = 1'b0;
    bus.req_valid            = 3'b010;
    bus.req_addr[1*AW +: AW] = 21'h00777;
    tick;
    chk("edge_req_ready", 64'(bus.req_ready), 64'h2);
    bus.req_valid = 3'b000;
    tick;
    tick;
    bus.mem_req_ready = 1'b1;
    tick;
    bus.mem_req_ready = 1'b0;
    chk("edge_in_wait", 64'(bus.mem_req_valid), 64'h0);
    repeat (4) tick;
    chk("edge_no_early_rsp", 64'(bus.rsp_valid), 64'h0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hA5A5;
    tick;
    chk("edge_rsp_valid", 64'(bus.rsp_valid), 64'h2);
    chk("edge_rsp_rdata", bus.rsp_rdata, 64'hA5A5);
    chk("edge_no_timeout", 64'(timeout_err), 64'h0);
    bus.mem_rsp_valid = 1'b0;

    // Reset while waiting for the DRAM response
    bus.req_valid            = 3'b001;
    bus.req_addr[0*AW +: AW] = 21'h00300;
    bus.mem_req_ready        = 1'b1;
    tick;
    chk("mid_req_ready", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 3'b000;
    tick;
    chk("mid_busy_before", 64'(busy), 64'h1);
    reset             = 1'b1;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'hBAD;
    #1;
    chk("mid_async_busy", 64'(busy), 64'h0);
    chk("mid_async_rdata", bus.rsp_rdata, 64'h0);
    chk("mid_async_mem_addr", 64'(bus.mem_req_addr), 64'h0);
    tick;
    chk("mid_rst_rsp", 64'(bus.rsp_valid), 64'h0);
    reset = 1'b0;
    tick;
    chk("mid_late_rsp_ignored", 64'(bus.rsp_valid), 64'h0);
    chk("mid_late_busy", 64'(busy), 64'h0);
    bus.mem_rsp_valid = 1'b0;
    bus.req_valid     = 3'b011;
    tick;
    chk("mid_first_grant", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 3'b010;
    tick;
    bus.req_valid     = 3'b000;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = 64'h77;
    tick;
    chk("mid_after_rsp", 64'(bus.rsp_valid), 64'h1);
    chk("mid_after_rdata", bus.rsp_rdata, 64'h77);
    bus.mem_rsp_valid = 1'b0;
    bus.mem_req_ready = 1'b0;
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
